laser_measure_sequencer: RTL and testbench

//  Sequences the laser distance measurer through a burst of SHOTS measurements per start request.

---
 rtl/laser_measure_sequencer.sv | 151 +++++++++++++++
 tb/tb_laser_measure_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_measure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : laser_measure_sequencer
// Description : Runs a burst of SHOTS laser distance measurements per start
//               request. Each shot is triggered, timed out and retried, and
//               the burst average is published with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_measure_sequencer #(
  parameter int SHOTS      = 4,
  parameter int LOG2_SHOTS = 2,
  parameter int TIMEOUT    = 65535,
  parameter int SETTLE     = 8,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        laser_reflect,
  input  logic [15:0] meas_data,
  output logic        meas_btn,
  output logic        meas_rst,
  output logic [15:0] avg_dist,
  output logic        valid,
  output logic        busy,
  output logic        error
);

  localparam int ACC_W   = 16 + LOG2_SHOTS;
  localparam int RETRY_W = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRE   = 3'd1,
    S_WAIT   = 3'd2,
    S_CAPT   = 3'd3,
    S_RECOV  = 3'd4,
    S_SETTLE = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [7:0]         r_shot_cnt;
  logic [15:0]        r_timer;
  logic [RETRY_W-1:0] r_retry;
  logic               r_phase;     // set during the second cycle of CAPT/RECOV
  logic [15:0]        r_avg;
  logic               r_error;

  logic [ACC_W-1:0]   w_acc_sum;
  logic               w_last_shot;
  logic               w_retry_max;
  logic               w_timeout;
  logic               w_settled;

  assign w_acc_sum   = r_acc + ACC_W'(meas_data);
  assign w_last_shot = (r_shot_cnt == 8'(SHOTS - 1));
  assign w_retry_max = (r_retry == RETRY_W'(MAX_RETRY));
  assign w_timeout   = (r_timer == 16'(TIMEOUT - 1));
  assign w_settled   = (r_timer == 16'(SETTLE - 1));

  assign avg_dist = r_avg;
  assign error    = r_error;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and state-derived outputs; reflect has priority over timeout
  always_comb begin
    w_next   = r_state;
    meas_btn = 1'b0;
    valid    = 1'b0;
    busy     = (r_state != S_IDLE);
    meas_rst = rst & (r_state != S_RECOV);
    case (r_state)
      S_IDLE:   if (start) w_next = S_FIRE;
      S_FIRE: begin
        meas_btn = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        if (laser_reflect)  w_next = S_CAPT;
        else if (w_timeout) w_next = S_RECOV;
      end
      S_CAPT:   if (r_phase) w_next = w_last_shot ? S_DONE : S_SETTLE;
      S_RECOV:  if (r_phase) w_next = w_retry_max ? S_DONE : S_SETTLE;
      S_SETTLE: if (w_settled) w_next = S_FIRE;
      S_DONE: begin
        valid  = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: timer, accumulator, shot/retry counters and published result.
  // The result is written on entry to DONE so it is already stable while valid is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc      <= '0;
      r_shot_cnt <= '0;
      r_timer    <= '0;
      r_retry    <= '0;
      r_phase    <= 1'b0;
      r_avg      <= '0;
      r_error    <= 1'b0;
    end else begin
      r_phase <= ((r_state == S_CAPT) || (r_state == S_RECOV)) ? ~r_phase : 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_shot_cnt <= '0;
            r_retry    <= '0;
            r_error    <= 1'b0;
          end
        end
        S_FIRE:   r_timer <= '0;
        S_WAIT:   r_timer <= r_timer + 16'd1;
        S_CAPT: begin
          r_timer <= '0;
          if (r_phase) begin
            r_acc      <= w_acc_sum;
            r_shot_cnt <= r_shot_cnt + 8'd1;
            r_retry    <= '0;
            if (w_last_shot) begin
              r_avg   <= w_acc_sum[LOG2_SHOTS +: 16];
              r_error <= 1'b0;
            end
          end
        end
        S_RECOV: begin
          r_timer <= '0;
          if (r_phase) begin
            if (w_retry_max) r_error <= 1'b1;
            else             r_retry <= r_retry + RETRY_W'(1);
          end
        end
        S_SETTLE: r_timer <= r_timer + 16'd1;
        default:  ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_measure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_measure_sequencer
// Description : Self-checking bench with a behavioural laser measurer and a
//               burst-level reference model (expected average, error flag,
//               trigger and recovery counts, timing relationships).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_measure_sequencer;

  localparam int SHOTS      = 4;
  localparam int LOG2_SHOTS = 2;
  localparam int TIMEOUT    = 120;
  localparam int SETTLE     = 8;
  localparam int MAX_RETRY  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        laser_reflect;
  logic [15:0] meas_data;
  logic        meas_btn;
  logic        meas_rst;
  logic [15:0] avg_dist;
  logic        valid;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  laser_measure_sequencer #(
    .SHOTS(SHOTS), .LOG2_SHOTS(LOG2_SHOTS), .TIMEOUT(TIMEOUT),
    .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .laser_reflect(laser_reflect),
    .meas_data(meas_data), .meas_btn(meas_btn), .meas_rst(meas_rst),
    .avg_dist(avg_dist), .valid(valid), .busy(busy), .error(error)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point for every check in the bench
  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-trigger response of the behavioural measurer: delay 0 means no reflection
  typedef struct {
    int          delay;
    logic [15:0] data;
  } resp_t;
  resp_t resp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int btn_cnt = 0, rec_cnt = 0, vld_cnt = 0;
  int last_btn_cyc = 0, last_low_cyc = 0, last_reflect_cyc = 0, low_run = 0;
  bit recov_pending = 0;

  // Output monitor: counts triggers/recoveries/valids and checks recovery timing
  always @(negedge clk) begin
    if (valid) vld_cnt++;
    if (meas_btn) begin
      btn_cnt++;
      last_btn_cyc = cyc;
      chk_eq("btn_not_in_meas_reset", meas_rst, 1);
      if (recov_pending) begin
        chk_eq("recov_to_fire_gap", cyc - last_low_cyc, SETTLE + 1);
        recov_pending = 0;
      end
    end
    if (rst && !meas_rst) begin
      if (low_run == 0) begin
        rec_cnt++;
        chk_eq("timeout_to_recov", cyc - last_btn_cyc, TIMEOUT + 1);
      end
      low_run++;
      last_low_cyc = cyc;
    end else begin
      if (low_run != 0 && rst) begin
        chk_eq("recov_len", low_run, 2);
        recov_pending = 1;
      end
      low_run = 0;
    end
  end

  // Behavioural measurer: reflect d cycles into WAIT, distance latched 2 cycles later
  initial begin : p_measurer
    resp_t r;
    laser_reflect = 1'b0;
    meas_data     = 16'd0;
    forever begin
      @(negedge clk);
      if (meas_btn) begin
        if (resp_q.size() > 0) r = resp_q.pop_front();
        else begin r.delay = 0; r.data = 16'd0; end
        meas_data = 16'($urandom);
        if (r.delay > 0) begin
          repeat (r.delay) @(posedge clk);
          #1 laser_reflect = 1'b1;
          last_reflect_cyc = cyc;
          @(posedge clk); #1 laser_reflect = 1'b0;
          @(posedge clk); #1 meas_data = r.data;
        end
      end
    end
  end

  // Burst description used by run_burst; timeouts before the shot succeeds
  int          shot_tmo[SHOTS];
  int          shot_delay[SHOTS];
  logic [15:0] shot_data[SHOTS];
  logic [15:0] model_avg = 16'd0;

  task automatic run_burst(input string name, input bit inj_start);
    int  exp_btn = 0, exp_rec = 0, nt;
    bit  exp_abort = 0, seen = 0, injected = 0;
    int  sum = 0, b0, r0, v0, waited = 0;
    resp_t r;
    resp_q.delete();
    for (int s = 0; s < SHOTS; s++) begin
      if (!exp_abort) begin
        nt = (shot_tmo[s] > MAX_RETRY) ? MAX_RETRY + 1 : shot_tmo[s];
        for (int k = 0; k < nt; k++) begin
          r.delay = 0; r.data = 16'd0;
          resp_q.push_back(r);
          exp_btn++; exp_rec++;
        end
        if (shot_tmo[s] > MAX_RETRY) exp_abort = 1;
        else begin
          r.delay = shot_delay[s]; r.data = shot_data[s];
          resp_q.push_back(r);
          exp_btn++;
          sum += int'(shot_data[s]);
        end
      end
    end
    if (!exp_abort) model_avg = 16'(sum / SHOTS);
    b0 = btn_cnt; r0 = rec_cnt; v0 = vld_cnt;
    recov_pending = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk_eq({name, "_busy_after_start"}, busy, 1);
    chk_eq({name, "_err_cleared"}, error, 0);
    while (!seen && waited < 8000) begin
      @(negedge clk);
      waited++;
      if (start) start = 1'b0;
      if (valid) seen = 1;
      else if (inj_start && !injected && (btn_cnt != b0) && (cyc - last_btn_cyc == 3)) begin
        start = 1'b1;
        injected = 1;
      end
    end
    chk_eq({name, "_valid_seen"}, seen, 1);
    if (seen) begin
      chk_eq({name, "_avg"}, avg_dist, model_avg);
      chk_eq({name, "_error"}, error, exp_abort);
      chk_eq({name, "_busy_at_valid"}, busy, 1);
      if (!exp_abort) chk_eq({name, "_latency"}, cyc - last_reflect_cyc, 3);
      if (inj_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_eq({name, "_busy_after_valid"}, busy, 0);
      chk_eq({name, "_valid_one_cycle"}, valid, 0);
    end
    repeat (SETTLE + 4) @(negedge clk);
    chk_eq({name, "_idle"}, busy, 0);
    chk_eq({name, "_avg_held"}, avg_dist, model_avg);
    chk_eq({name, "_btn_count"}, btn_cnt - b0, exp_btn);
    chk_eq({name, "_recov_count"}, rec_cnt - r0, exp_rec);
    chk_eq({name, "_valid_count"}, vld_cnt - v0, 1);
  endtask

  task automatic set_burst(input int delay, input int tmo_shot, input int tmo_n);
    for (int s = 0; s < SHOTS; s++) begin
      shot_delay[s] = (delay > 0) ? delay : int'($urandom_range(1, TIMEOUT));
      shot_data[s]  = 16'($urandom);
      shot_tmo[s]   = (s == tmo_shot) ? tmo_n : 0;
    end
  endtask

  initial begin : p_main
    int b0, v0, waited;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_valid", valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_avg", avg_dist, 0);
    chk_eq("rst_error", error, 0);
    chk_eq("rst_btn", meas_btn, 0);
    chk_eq("rst_meas_rst", meas_rst, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk_eq("post_rst_meas_rst", meas_rst, 1);

    // Fixed distances 100,102,98,104 reflecting after 100 cycles
    set_burst(100, -1, 0);
    shot_data[0] = 16'd100; shot_data[1] = 16'd102;
    shot_data[2] = 16'd98;  shot_data[3] = 16'd104;
    run_burst("basic", 0);
    chk_eq("basic_avg_101", avg_dist, 101);

    // Second shot times out once and is retried
    set_burst(0, 1, 1);
    run_burst("retry1", 0);

    // Reflection arriving exactly on the last timeout cycle wins
    set_burst(TIMEOUT, -1, 0);
    run_burst("coincide", 0);

    // Retries exhausted only after the last allowed attempt succeeds
    set_burst(0, 2, MAX_RETRY);
    run_burst("max_retry_ok", 0);

    // No reflection at all: abort, previous average kept
    set_burst(0, 0, MAX_RETRY + 1);
    run_burst("abort", 0);

    // Start pulses during WAIT and on the valid cycle are ignored
    set_burst(0, -1, 0);
    shot_delay[0] = 40;
    run_burst("start_ignored", 1);

    // Reset during the first CAPT cycle discards the burst
    set_burst(20, -1, 0);
    resp_q.delete();
    for (int s = 0; s < SHOTS; s++) resp_q.push_back('{shot_delay[s], shot_data[s]});
    b0 = btn_cnt; v0 = vld_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!laser_reflect && waited < 1000);
    chk_eq("rstcapt_reflect_seen", laser_reflect, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("rstcapt_meas_rst_low", meas_rst, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk_eq("rstcapt_idle", busy, 0);
    chk_eq("rstcapt_no_valid", valid, 0);
    repeat (200) @(negedge clk);
    chk_eq("rstcapt_valid_count", vld_cnt - v0, 0);
    chk_eq("rstcapt_btn_count", btn_cnt - b0, 1);
    chk_eq("rstcapt_avg_cleared", avg_dist, 0);
    resp_q.delete();
    model_avg = 16'd0;

    // Randomised bursts: occasional timeouts and rare aborts
    for (int b = 0; b < 8; b++) begin
      for (int s = 0; s < SHOTS; s++) begin
        shot_delay[s] = int'($urandom_range(1, TIMEOUT));
        shot_data[s]  = 16'($urandom);
        shot_tmo[s]   = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, MAX_RETRY));
        if ($urandom_range(0, 19) == 0) shot_tmo[s] = MAX_RETRY + 1;
      end
      run_burst($sformatf("rand%0d", b), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
